serial_ripple_borrow_subtractor: RTL and testbench

Bit-serial subtractor built around a single full-subtractor cell. It computes i_min − i_sub one bit per clock, LSB first, with a registered ripple borrow. It is the inverse-operation companion to the team's combinational ripple-carry adder and keeps the same result format: borrow in the MSB above the WIDTH-bit difference. It trades WIDTH cycles of latency for one cell of logic and is driven by a start/busy/done handshake.

---
 rtl/serial_ripple_borrow_subtractor_pkg.sv | 15 +
 rtl/serial_ripple_borrow_subtractor_full_subtractor.sv | 13 +
 rtl/serial_ripple_borrow_subtractor.sv | 86 ++++++++
 tb/tb_serial_ripple_borrow_subtractor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_ripple_borrow_subtractor_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial borrow subtractor.
package serial_ripple_borrow_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_ripple_borrow_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - borrow_in.
module full_subtractor (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_borrow,
    output logic o_diff,
    output logic o_borrow
);

    assign o_diff   = i_bit1 ^ i_bit2 ^ i_borrow;
    assign o_borrow = (~i_bit1 & i_bit2) | (~(i_bit1 ^ i_bit2) & i_borrow);

endmodule

// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial i_min - i_sub, LSB first, one full-subtractor cell and a registered borrow.
module serial_ripple_borrow_subtractor
    import serial_ripple_borrow_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH:0]   o_result
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] min_sr;
    logic [WIDTH-1:0] sub_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;

    full_subtractor u_fs (
        .i_bit1  (min_sr[0]),
        .i_bit2  (sub_sr[0]),
        .i_borrow(borrow),
        .o_diff  (d),
        .o_borrow(bout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            min_sr   <= '0;
            sub_sr   <= '0;
            diff_sr  <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        min_sr <= i_min;
                        sub_sr <= i_sub;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    diff_sr <= {d, diff_sr[WIDTH-1:1]};
                    min_sr  <= {1'b0, min_sr[WIDTH-1:1]};
                    sub_sr  <= {1'b0, sub_sr[WIDTH-1:1]};
                    borrow  <= bout;
                    // Final bit: publish the result directly, counter stays put.
                    if (cnt == CW'(WIDTH - 1)) begin
                        o_result <= {bout, d, diff_sr[WIDTH-1:1]};
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Self-checking bench: directed test plan plus random operands at WIDTH 8 and 13.
module tb_serial_ripple_borrow_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  min8 = '0, sub8 = '0;
    logic        busy8, done8;
    logic [8:0]  res8;

    logic        start13 = 1'b0;
    logic [12:0] min13 = '0, sub13 = '0;
    logic        busy13, done13;
    logic [13:0] res13;

    logic        fa = 1'b0, fb = 1'b0, fbin = 1'b0;
    logic        fd, fbout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_ripple_borrow_subtractor #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_min(min8), .i_sub(sub8),
        .o_busy(busy8), .o_done(done8), .o_result(res8)
    );

    serial_ripple_borrow_subtractor #(.WIDTH(13)) dut13 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start13), .i_min(min13), .i_sub(sub13),
        .o_busy(busy13), .o_done(done13), .o_result(res13)
    );

    full_subtractor u_fs (
        .i_bit1(fa), .i_bit2(fb), .i_borrow(fbin), .o_diff(fd), .o_borrow(fbout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: borrow flag is plain unsigned compare, difference is mod 2^w.
    function automatic logic [31:0] model(input int w, input logic [12:0] a, input logic [12:0] b);
        longint diff;
        longint mask;
        diff = longint'(a) - longint'(b);
        mask = (longint'(1) << w) - 1;
        return 32'(((a < b) ? (longint'(1) << w) : 0) | (diff & mask));
    endfunction

    task automatic run_op(input bit w13, input logic [12:0] a, input logic [12:0] b,
                          input bit disturb, output logic [31:0] res,
                          output int edges, output int busy_n);
        @(negedge clk);
        if (w13) begin min13 = a; sub13 = b; start13 = 1'b1; end
        else begin min8 = a[7:0]; sub8 = b[7:0]; start8 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; start13 = 1'b0;
        edges = 0; busy_n = 0;
        while (!(w13 ? done13 : done8) && edges < 40) begin
            if (w13 ? busy13 : busy8) busy_n++;
            if (disturb && edges == 3) begin
                start8 = 1'b1; min8 = 8'($urandom); sub8 = 8'($urandom);
            end
            if (disturb && edges == 4) start8 = 1'b0;
            @(negedge clk);
            edges++;
        end
        res = w13 ? 32'(res13) : 32'(res8);
        chk("done_seen", 32'(w13 ? done13 : done8), 1);
        chk("busy_at_done", 32'(w13 ? busy13 : busy8), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(w13 ? done13 : done8), 0);
    endtask

    initial begin
        logic [31:0] r;
        int e, bn, gap;
        bit held, seen;
        logic [12:0] ra, rb;

        // Full subtractor truth table via integer a - b - bin.
        for (int i = 0; i < 8; i++) begin
            int s;
            fa = i[2]; fb = i[1]; fbin = i[0];
            #1;
            s = int'(fa) - int'(fb) - int'(fbin);
            chk("fs_diff", 32'(fd), 32'(s & 1));
            chk("fs_borrow", 32'(fbout), (s < 0) ? 1 : 0);
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_result", 32'(res8), 0);
        chk("rst_result13", 32'(res13), 0);
        rst_n = 1'b1;

        run_op(1'b0, 13'd100, 13'd37, 1'b0, r, e, bn);
        chk("t1_result", r, 32'h03F);
        chk("t1_latency", 32'(e), 8);
        chk("t1_busy_cycles", 32'(bn), 8);

        run_op(1'b0, 13'd37, 13'd100, 1'b0, r, e, bn);
        chk("t2_result", r, 32'h1C1);
        run_op(1'b0, 13'd0, 13'd1, 1'b0, r, e, bn);
        chk("t2_zero_minus_one", r, 32'h1FF);

        run_op(1'b0, 13'd255, 13'd255, 1'b0, r, e, bn);
        chk("t3_equal", r, 32'h000);
        run_op(1'b0, 13'd255, 13'd0, 1'b0, r, e, bn);
        chk("t3_max_minus_zero", r, 32'h0FF);

        // Back-to-back with start held through DONE.
        @(negedge clk); min8 = 8'd10; sub8 = 8'd3; start8 = 1'b1;
        @(negedge clk); min8 = 8'd3; sub8 = 8'd10;
        e = 0;
        while (!done8 && e < 40) begin @(negedge clk); e++; end
        chk("t4_first_done", 32'(done8), 1);
        chk("t4_first_result", 32'(res8), 32'h007);
        @(negedge clk); start8 = 1'b0;
        gap = 1; held = 1'b1;
        while (!done8 && gap < 40) begin
            if (res8 !== 9'h007) held = 1'b0;
            @(negedge clk); gap++;
        end
        chk("t4_done_gap", 32'(gap), 9);
        chk("t4_result_held", 32'(held), 1);
        chk("t4_second_result", 32'(res8), 32'h1F9);
        @(negedge clk);

        // Start pulse and operand churn mid-RUN must not disturb the latched op.
        run_op(1'b0, 13'd200, 13'd77, 1'b1, r, e, bn);
        chk("t5_ignore_midrun", r, model(8, 13'd200, 13'd77));
        chk("t5_latency", 32'(e), 8);

        // Asynchronous reset partway through an operation.
        @(negedge clk); min8 = 8'd90; sub8 = 8'd45; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy8), 0);
        chk("t6_done", 32'(done8), 0);
        chk("t6_result", 32'(res8), 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        chk("t6_no_done_after_abort", 32'(seen), 0);
        run_op(1'b0, 13'd90, 13'd45, 1'b0, r, e, bn);
        chk("t6_recover", r, 32'h02D);

        for (int i = 0; i < 1000; i++) begin
            ra = 13'($urandom); rb = 13'($urandom);
            if (i < 4) begin ra = (i[0]) ? 13'h1FFF : 13'h0; rb = (i[1]) ? 13'h1FFF : 13'h0; end
            run_op(1'b0, {5'b0, ra[7:0]}, {5'b0, rb[7:0]}, 1'b0, r, e, bn);
            chk("rand8", r, model(8, {5'b0, ra[7:0]}, {5'b0, rb[7:0]}));
            run_op(1'b1, ra, rb, 1'b0, r, e, bn);
            chk("rand13", r, model(13, ra, rb));
            chk("rand13_latency", 32'(e), 13);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
